// File: rtl/seq_detect_scheduler.sv
// seq_detect_scheduler: one "1011" detector core time-shared round-robin
// across NCH serial channels, with per-channel saved context and
// saturating per-channel match counters.
module seq_detect_scheduler #(
  parameter  int unsigned NCH = 4,
  parameter  int unsigned CW  = 8,
  localparam int unsigned IW  = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en_i,
  input  logic [NCH-1:0] ch_valid_i,
  input  logic [NCH-1:0] ch_bit_i,
  input  logic [NCH-1:0] ch_flush_i,
  output logic [NCH-1:0] ch_ready_o,
  output logic           hit_valid_o,
  output logic [IW-1:0]  hit_ch_o,
  input  logic [IW-1:0]  cnt_sel_i,
  input  logic           cnt_clr_i,
  output logic [CW-1:0]  cnt_rdata_o
);

  typedef enum logic [1:0] {S0, S1, S2, S3} det_state_e;

  det_state_e      ctx_q [NCH];
  det_state_e      ctx_d [NCH];
  logic [CW-1:0]   cnt_q [NCH];
  logic [CW-1:0]   cnt_d [NCH];
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            hit_valid_q, hit_valid_d;
  logic [IW-1:0]   hit_ch_q, hit_ch_d;

  logic [NCH-1:0]  elig;
  logic [IW-1:0]   cand;
  logic            gnt_vld;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_bit;
  logic            match;

  // Round-robin grant: first eligible channel searching upward from ptr+1.
  // Reset gates eligibility so ch_ready stays low while rst is held.
  always_comb begin
    elig       = ch_valid_i & ~ch_flush_i & {NCH{en_i & ~rst}};
    cand       = '0;
    gnt_vld    = 1'b0;
    gnt_idx    = ptr_q;
    ch_ready_o = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      cand = ptr_q + IW'(k);
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_vld) ch_ready_o[gnt_idx] = 1'b1;
  end

  // Detector step on the granted context, flush override, hit and counter update.
  always_comb begin
    ctx_d       = ctx_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    hit_valid_d = 1'b0;
    hit_ch_d    = hit_ch_q;
    match       = 1'b0;
    gnt_bit     = ch_bit_i[gnt_idx];
    if (gnt_vld) begin
      ptr_d = gnt_idx;
      case (ctx_q[gnt_idx])
        S0: ctx_d[gnt_idx] = gnt_bit ? S1 : S0;
        S1: ctx_d[gnt_idx] = gnt_bit ? S1 : S2;
        S2: ctx_d[gnt_idx] = gnt_bit ? S3 : S0;
        S3: begin
          ctx_d[gnt_idx] = gnt_bit ? S1 : S2;
          match          = gnt_bit;
        end
        default: ctx_d[gnt_idx] = S0;
      endcase
    end
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ch_flush_i[i]) ctx_d[i] = S0;
    end
    if (match) begin
      hit_valid_d = 1'b1;
      hit_ch_d    = gnt_idx;
      if (cnt_q[gnt_idx] != '1) cnt_d[gnt_idx] = cnt_q[gnt_idx] + CW'(1);
    end
    // Clear wins over a same-cycle increment on the selected channel.
    if (cnt_clr_i) cnt_d[cnt_sel_i] = '0;
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        ctx_q[i] <= S0;
        cnt_q[i] <= '0;
      end
      ptr_q       <= IW'(NCH - 1);
      hit_valid_q <= 1'b0;
      hit_ch_q    <= '0;
    end else begin
      ctx_q       <= ctx_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      hit_valid_q <= hit_valid_d;
      hit_ch_q    <= hit_ch_d;
    end
  end

  assign hit_valid_o = hit_valid_q;
  assign hit_ch_o    = hit_ch_q;
  assign cnt_rdata_o = cnt_q[cnt_sel_i];

endmodule

// File: doc/seq_detect_scheduler.md
# seq_detect_scheduler

Time-shares a single "1011" serial sequence-detector core among NCH independent serial bit channels. A round-robin arbiter grants at most one channel per cycle. The granted channel's bit advances that channel's saved detector context, and the saved context is written back. The block reports each match with its channel number and keeps a saturating match counter per channel, readable by the control side.

## Interface
- NCH, 4: number of channels; power of two, ≥2.
- CW, 8: width of each per-channel match counter.
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  global enable; low = no grants, all state held.
- ch_valid  in  NCH  channel i has a bit available.
- ch_bit  in  NCH  serial bit of channel i.
- ch_flush  in  NCH  force channel i context to S0.
- ch_ready  out  NCH  one-hot/zero; bit i high = channel i's bit consumed this cycle.
- hit_valid  out  1  registered match pulse.
- hit_ch  out  $clog2(NCH)  channel that matched; valid with hit_valid.
- cnt_sel  in  $clog2(NCH)  counter read/clear select.
- cnt_clr  in  1  clear counter[cnt_sel] at next edge.
- cnt_rdata  out  CW  counter[cnt_sel], combinational read.

## Operation
- Per-channel context: 2-bit detector state. S0 = nothing matched. S1 = "1". S2 = "10". S3 = "101".
- Transitions on consumed bit b:
  - S0: b=1 → S1, b=0 → S0.
  - S1: 1 → S1, 0 → S2.
  - S2: 1 → S3, 0 → S0.
  - S3: 1 → S1 with match, 0 → S2.
- Overlapping detection: "1011011" yields two matches.
- Only one detector step per cycle. Contexts of non-granted channels are unchanged.
- Arbitration: eligible(i) = en & ch_valid[i] & ~ch_flush[i].
  - Grant the first eligible channel searching upward from ptr+1, modulo NCH.
  - On a grant, ptr ← granted index. With no grant, ptr holds.
- ch_ready[grant] = 1 in the grant cycle. The requester treats that bit as consumed and may present its next bit in the following cycle.
- Flush: ch_flush[i] sets ctx[i] ← S0 at the next edge. Channel i is not granted in that cycle. Flush takes precedence over everything for that channel.
- Match on granted channel g:
  - Next edge: hit_valid ← 1 and hit_ch ← g.
  - counter[g] increments at that edge, saturating at 2^CW−1.
- No match: hit_valid ← 0 and hit_ch holds its previous value.
- cnt_clr with simultaneous increment on the same channel: clear wins, so the counter becomes 0. A clear on a different channel does not affect the increment.
- en low:
  - ch_ready = 0 and hit_valid ← 0.
  - Contexts, ptr and counters hold.
  - ch_flush and cnt_clr still act.

## Timing
- Reset values:
  - All ctx = S0 and all counters = 0.
  - ptr = NCH−1, so channel 0 wins first.
  - hit_valid = 0 and hit_ch = 0.
  - ch_ready = 0 while rst is high; cnt_rdata = 0.
- ch_ready is combinational from ch_valid, ch_flush, en and ptr, with no register. The requester must not make ch_valid depend on ch_ready.
- Latency: 4th bit of a pattern consumed in cycle N → hit_valid high in cycle N+1 for exactly one cycle per match.
- Back-to-back matches from different channels in consecutive cycles produce consecutive hit_valid cycles with updated hit_ch.
- Fairness: with all NCH channels continuously valid, each channel is granted once every NCH cycles.
- cnt_rdata reflects a clear or increment in the cycle after the edge that applied it.
- Reset asserted mid-operation:
  - All state returns to reset values immediately, asynchronously.
  - Partial patterns are lost.
  - No hit_valid is generated for bits consumed before the reset.

## Test plan
- Single channel, overlap: ch0 streams 1,0,1,1,0,1,1 while the other channels are idle. hit_valid with hit_ch=0 appears one cycle after the 4th and the 7th grants. counter[0]=2.
- Interleaving: ch0 and ch1 both continuously valid, each sending 1,0,1,1. Grants alternate 0,1,0,1,…. Hits occur on ch0 after its 4th bit and on ch1 one cycle later. Contexts do not cross-contaminate.
- Fairness: all 4 channels valid for 8 cycles after reset. Grant order is 0,1,2,3,0,1,2,3 and ch_ready is one-hot every cycle.
- Flush: ch0 sends 1,0,1, then ch_flush[0] pulses with ch_valid[0]=1, then ch0 sends 1. No hit is produced. ch_ready[0]=0 in the flush cycle.
- Counters, CW=2:
  - 5 matches on ch2 leave counter[2]=3 (saturated).
  - cnt_clr with cnt_sel=2 in the same cycle as a ch2 match leaves counter[2]=0.
  - A clear of ch1 in the same cycle as a ch2 match still increments ch2.
- Reset mid-pattern: ch3 sends 1,0,1, then rst pulses asynchronously between edges, then ch3 sends 1. No hit. All counters read 0, and the next grant with all channels valid goes to ch0.
